bresenham_fill: RTL and testbench
=================================

BRESENHAM_FILL -- requirements
Module: bresenham_fill

Interface
REQ-001 SHALL have parameter H_RES, default 320, meaning pixels per frame-buffer row used in address computation.
REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-004 SHALL have port req_2, input, 1, meaning start-fill request, sampled in IDLE only.
REQ-005 SHALL have port ack_2, output, 1, meaning one-cycle fill-complete pulse.
REQ-006 SHALL have port point_out_a_x, input, 8, meaning span endpoint A x-coordinate.
REQ-007 SHALL have port point_out_b_xy, input, 16, meaning [15:8] is endpoint B x and [7:0] is row y.
REQ-008 SHALL have port rgb, input, 24, meaning fill colour, with R in [23:16], G in [15:8] and B in [7:0].
REQ-009 SHALL have ports rdata, gdata and bdata, output, 8 each, meaning the colour channels of the current write.
REQ-010 SHALL have port waddr, output, 18, meaning the frame-buffer write address.
REQ-011 SHALL have port we, output, 1, meaning the frame-buffer write enable, one pixel per high cycle.

Function
REQ-012 SHALL implement states IDLE, FILL and DONE; all outputs SHALL be registered.
REQ-013 In IDLE with req_2=1 at an edge, SHALL latch x_lo=min(xA,xB), x_hi=max(xA,xB), y and rgb, and go to FILL.
- On that same edge: we=1, waddr=y*H_RES+x_lo, rdata/gdata/bdata = latched colour.
REQ-014 In FILL, each edge: if current x==x_hi, go to DONE with we=0 and ack_2=1; else x+1, with we=1 and waddr+1.
REQ-015 DONE SHALL last one cycle: ack_2 returns to 0 and state goes to IDLE; ack_2 is high exactly one cycle per request.
REQ-016 Span SHALL be inclusive: N=x_hi-x_lo+1 consecutive we cycles, followed immediately by the ack cycle.
- Latency from req edge to ack high is N+1 edges.
REQ-017 xA==xB SHALL write exactly one pixel.
REQ-018 Full span 0..255 SHALL write 256 pixels with no 8-bit wrap of the x counter (9-bit compare or equality before increment).
REQ-019 req_2 during FILL or DONE SHALL be ignored, and input changes after latching SHALL have no effect.
REQ-020 Address arithmetic SHALL be performed at 18 bits: y*H_RES+x, max 255*320+255=81855.
REQ-021 When we=0, waddr and the colour outputs SHALL hold their last values.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, we=0, ack_2=0, waddr=0 and rdata=gdata=bdata=0.
REQ-023 rst asserted mid-fill SHALL abort the span without ack_2; after rst deasserts, the next req_2 starts a fresh fill.

Configuration
REQ-024 Macro FILL_ENDPOINT_SWAP_EN:
- Defined: endpoints are ordered per REQ-013.
- Undefined: x_lo=xA and x_hi=xB; if xA>xB, only pixel xA is written, then ack_2.

Structure
REQ-025 Package bresenham_pkg SHALL hold:
- the state enum typedef (IDLE, FILL, DONE);
- COORD_W=8, ADDR_W=18 and COLOR_W=24;
- the default H_RES.
REQ-026 Sub-module bresenham_fill_addr SHALL compute y*H_RES+x combinationally; it is the only sub-module.

Verification
REQ-027 Basic fill: rgb=AABBCC, xA=0, xB=1, y=0x32, one-cycle req_2 -> we high 2 cycles, then ack_2 high 1 cycle.
- Writes go to waddr 16000 then 16001.
- r/g/b = AA/BB/CC.
REQ-028 Reversed endpoints: xA=10, xB=5, y=0 -> waddr 5..10 (6 writes), then ack_2.
- Without FILL_ENDPOINT_SWAP_EN: only waddr 10 is written, then ack_2.
REQ-029 Single pixel: xA=xB=7, y=1 -> one write at waddr 327, then ack_2 the next cycle.
REQ-030 Full row: xA=0, xB=255, y=255 -> 256 writes at waddr 81600..81855, no wrap, one ack_2.
REQ-031 Reset mid-fill: assert rst during the 3rd write cycle -> we=0 and ack_2=0 immediately, state IDLE.
- A new req_2 after release completes normally.
REQ-032 Busy request: pulse req_2 again during FILL -> ignored, exactly one ack_2, and the write count is unchanged.

Source files
------------

// File: rtl/bresenham_pkg.sv
// ---------------------------------------------------------------------------
// bresenham_pkg
// Shared types and constants for the horizontal span filler.
//   fill_state_t  : IDLE / FILL / DONE controller states
//   COORD_W       : width of one x or y coordinate
//   ADDR_W        : frame-buffer address width (covers 255*320+255 = 81855)
//   COLOR_W       : packed RGB colour width
//   H_RES_DEFAULT : default pixels per frame-buffer row
// ---------------------------------------------------------------------------
package bresenham_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    localparam int COORD_W       = 8;
    localparam int ADDR_W        = 18;
    localparam int COLOR_W       = 24;
    localparam int H_RES_DEFAULT = 320;

endpackage

// File: rtl/bresenham_fill_addr.sv
// ---------------------------------------------------------------------------
// bresenham_fill_addr
// Combinational linear frame-buffer address: addr = y * H_RES + x.
// All arithmetic is done at the full address width so the largest pixel
// (255, 255) lands at 81855 without truncation.
// Ports:
//   x    in  COORD_W  column
//   y    in  COORD_W  row
//   addr out ADDR_W   linear write address
// ---------------------------------------------------------------------------
module bresenham_fill_addr
    import bresenham_pkg::*;
#(
    parameter int H_RES = H_RES_DEFAULT
)
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr
);

    localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(H_RES);

    assign addr = ADDR_W'(y) * ROW_PITCH + ADDR_W'(x);

endmodule

// File: rtl/bresenham_fill.sv
// ---------------------------------------------------------------------------
// bresenham_fill
// Fills one horizontal span of a frame buffer with a solid colour, one pixel
// per clock. A request in IDLE latches the span and emits the first write on
// the same edge; FILL walks x up to the right end; DONE pulses ack_2 once.
//
// Configuration macro: FILL_ENDPOINT_SWAP_EN
//   defined   : endpoints are ordered, span is min(xA,xB)..max(xA,xB)
//   undefined : span is xA..xB; when xA > xB only pixel xA is written
//
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   asynchronous active-high reset
//   req_2           in   start-fill request, sampled in IDLE only
//   ack_2           out  one-cycle fill-complete pulse
//   point_out_a_x   in   [7:0] endpoint A x
//   point_out_b_xy  in   [15:8] endpoint B x, [7:0] row y
//   rgb             in   fill colour {R,G,B}
//   rdata/gdata/bdata out colour channels of the current write
//   waddr           out  frame-buffer write address
//   we              out  frame-buffer write enable
// ---------------------------------------------------------------------------
module bresenham_fill
    import bresenham_pkg::*;
#(
    parameter int H_RES = H_RES_DEFAULT
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_2,
    output logic                 ack_2,
    input  logic [COORD_W-1:0]   point_out_a_x,
    input  logic [2*COORD_W-1:0] point_out_b_xy,
    input  logic [COLOR_W-1:0]   rgb,
    output logic [7:0]           rdata,
    output logic [7:0]           gdata,
    output logic [7:0]           bdata,
    output logic [ADDR_W-1:0]    waddr,
    output logic                 we
);

    fill_state_t        state, state_nxt;
    logic [COORD_W-1:0] x_cur, x_cur_nxt;
    logic [COORD_W-1:0] x_hi, x_hi_nxt;
    logic               we_nxt, ack_nxt;
    logic [ADDR_W-1:0]  waddr_nxt, base_addr;
    logic [7:0]         r_nxt, g_nxt, b_nxt;

    logic [COORD_W-1:0] a_x, b_x, row_y;
    logic [COORD_W-1:0] span_lo, span_hi;

    assign a_x   = point_out_a_x;
    assign b_x   = point_out_b_xy[2*COORD_W-1:COORD_W];
    assign row_y = point_out_b_xy[COORD_W-1:0];

`ifdef FILL_ENDPOINT_SWAP_EN
    assign span_lo = (a_x <= b_x) ? a_x : b_x;
    assign span_hi = (a_x <= b_x) ? b_x : a_x;
`else
    // A reversed pair collapses to the single pixel xA; clamping the end to
    // xA keeps the equality stop from running past 255 and wrapping.
    assign span_lo = a_x;
    assign span_hi = (a_x > b_x) ? a_x : b_x;
`endif

    bresenham_fill_addr #(
        .H_RES (H_RES)
    ) u_addr (
        .x    (span_lo),
        .y    (row_y),
        .addr (base_addr)
    );

    // Next-state and next-output logic. Every output is registered, so this
    // block decides what the outputs become on the coming edge. The stop
    // test is equality before increment, so x never has to count past 255.
    always_comb begin
        state_nxt = state;
        x_cur_nxt = x_cur;
        x_hi_nxt  = x_hi;
        we_nxt    = 1'b0;
        ack_nxt   = 1'b0;
        waddr_nxt = waddr;
        r_nxt     = rdata;
        g_nxt     = gdata;
        b_nxt     = bdata;

        case (state)
            IDLE: begin
                if (req_2) begin
                    state_nxt = FILL;
                    x_cur_nxt = span_lo;
                    x_hi_nxt  = span_hi;
                    we_nxt    = 1'b1;
                    waddr_nxt = base_addr;
                    r_nxt     = rgb[23:16];
                    g_nxt     = rgb[15:8];
                    b_nxt     = rgb[7:0];
                end
            end
            FILL: begin
                if (x_cur == x_hi) begin
                    state_nxt = DONE;
                    ack_nxt   = 1'b1;
                end else begin
                    x_cur_nxt = x_cur + 1'b1;
                    we_nxt    = 1'b1;
                    waddr_nxt = waddr + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any span without an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            x_cur <= '0;
            x_hi  <= '0;
            we    <= 1'b0;
            ack_2 <= 1'b0;
            waddr <= '0;
            rdata <= '0;
            gdata <= '0;
            bdata <= '0;
        end else begin
            state <= state_nxt;
            x_cur <= x_cur_nxt;
            x_hi  <= x_hi_nxt;
            we    <= we_nxt;
            ack_2 <= ack_nxt;
            waddr <= waddr_nxt;
            rdata <= r_nxt;
            gdata <= g_nxt;
            bdata <= b_nxt;
        end
    end

endmodule

// File: tb/tb_bresenham_fill.sv
// ---------------------------------------------------------------------------
// tb_bresenham_fill
// Self-checking bench for bresenham_fill. Each span is predicted as a list
// of pixel addresses (row * H_RES + column) from the endpoint rules, then
// compared against the writes seen on the bus, together with the colour,
// the single ack and its position right after the last write.
// Honours FILL_ENDPOINT_SWAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_bresenham_fill;

    localparam int H_RES = 320;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_2 = 1'b0;
    logic        ack_2;
    logic [7:0]  point_out_a_x = '0;
    logic [15:0] point_out_b_xy = '0;
    logic [23:0] rgb = '0;
    logic [7:0]  rdata, gdata, bdata;
    logic [17:0] waddr;
    logic        we;

    int compared = 0;
    int mismatched = 0;

    bresenham_fill #(
        .H_RES (H_RES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_2          (req_2),
        .ack_2          (ack_2),
        .point_out_a_x  (point_out_a_x),
        .point_out_b_xy (point_out_b_xy),
        .rgb            (rgb),
        .rdata          (rdata),
        .gdata          (gdata),
        .bdata          (bdata),
        .waddr          (waddr),
        .we             (we)
    );

    always #5 clk = ~clk;

    // One comparison: counted, and reported on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
                   tag, observed, observed, expected, expected);
        end
    endtask

    // Issue one fill request and check the whole transaction against the
    // predicted pixel list. With busy set, a second request is pulsed while
    // the span is still being written and must change nothing.
    task automatic applyStimulus(input string name, input int xa, input int xb,
                                 input int y, input logic [23:0] colour,
                                 input bit busy);
        int exp_addr[$];
        int got_addr[$];
        int ack_count = 0;
        int ack_cycle = -1;
        int n;
        int lo;
        int hi;

`ifdef FILL_ENDPOINT_SWAP_EN
        lo = (xa < xb) ? xa : xb;
        hi = (xa < xb) ? xb : xa;
`else
        lo = xa;
        hi = (xa > xb) ? xa : xb;
`endif
        for (int x = lo; x <= hi; x++) exp_addr.push_back(y * H_RES + x);
        n = exp_addr.size();

        @(negedge clk);
        point_out_a_x  = 8'(xa);
        point_out_b_xy = {8'(xb), 8'(y)};
        rgb            = colour;
        req_2          = 1'b1;

        // Inputs are scrambled once latched; the span must not notice.
        @(negedge clk);
        req_2          = 1'b0;
        point_out_a_x  = 8'($urandom);
        point_out_b_xy = 16'($urandom);
        rgb            = 24'($urandom);

        for (int c = 1; c <= n + 4; c++) begin
            if (c > 1) @(negedge clk);
            if (we) begin
                got_addr.push_back(int'(waddr));
                checkOutput({name, " colour"}, 32'({rdata, gdata, bdata}), 32'(colour));
            end
            if (ack_2) begin
                ack_count++;
                if (ack_cycle < 0) ack_cycle = c;
            end
            req_2 = busy && (c == 2);
        end
        req_2 = 1'b0;

        checkOutput({name, " write count"}, 32'(got_addr.size()), 32'(n));
        for (int i = 0; i < got_addr.size() && i < n; i++)
            checkOutput({name, $sformatf(" waddr[%0d]", i)}, 32'(got_addr[i]), 32'(exp_addr[i]));
        checkOutput({name, " ack count"}, 32'(ack_count), 32'd1);
        checkOutput({name, " ack cycle"}, 32'(ack_cycle), 32'(n + 1));
        checkOutput({name, " idle we"}, 32'(we), 32'd0);
        checkOutput({name, " waddr hold"}, 32'(waddr), 32'(exp_addr[n-1]));
        checkOutput({name, " colour hold"}, 32'({rdata, gdata, bdata}), 32'(colour));
    endtask

    initial begin
        int quiet;

        $display("[TB] reset state");
        #3;
        checkOutput("reset we", 32'(we), 32'd0);
        checkOutput("reset ack_2", 32'(ack_2), 32'd0);
        checkOutput("reset waddr", 32'(waddr), 32'd0);
        checkOutput("reset colour", 32'({rdata, gdata, bdata}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed spans");
        applyStimulus("basic", 0, 1, 8'h32, 24'hAABBCC, 1'b0);
        applyStimulus("reversed", 10, 5, 0, 24'h123456, 1'b0);
        applyStimulus("single", 7, 7, 1, 24'h0F0F0F, 1'b0);
        applyStimulus("full row", 0, 255, 255, 24'hFFFFFF, 1'b0);
        applyStimulus("busy req", 20, 30, 9, 24'h5A5AA5, 1'b1);

        $display("[TB] reset mid-fill");
        @(negedge clk);
        point_out_a_x  = 8'd0;
        point_out_b_xy = {8'd9, 8'd2};
        rgb            = 24'h445566;
        req_2          = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_2 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("third write we", 32'(we), 32'd1);
        checkOutput("third write waddr", 32'(waddr), 32'(2 * H_RES + 2));
        rst = 1'b1;
        #1;
        checkOutput("abort we", 32'(we), 32'd0);
        checkOutput("abort ack_2", 32'(ack_2), 32'd0);
        checkOutput("abort waddr", 32'(waddr), 32'd0);
        checkOutput("abort colour", 32'({rdata, gdata, bdata}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        quiet = 0;
        repeat (12) begin
            @(negedge clk);
            if (we || ack_2) quiet++;
        end
        checkOutput("no activity after abort", 32'(quiet), 32'd0);
        applyStimulus("after reset", 3, 6, 4, 24'h778899, 1'b0);

        $display("[TB] random spans");
        for (int t = 0; t < 8; t++) begin
            applyStimulus($sformatf("random %0d", t),
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), 24'($urandom), t[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
